// File: rtl/dm_port_arbiter.sv
// Shares the synchronous-read data RAM between the MEM stage and a read-only debug port.
// MEM has priority; a starvation counter forces a debug read through after STARVE_MAX MEM wins.
module dm_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_MEM  = 2'd1,
        RD_DBG  = 2'd2
    } rd_owner_e;

    rd_owner_e           rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0]   mem_hold_q, mem_hold_d;
    logic [DATA_W-1:0]   dbg_hold_q, dbg_hold_d;
    logic                starve_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner_q   <= RD_NONE;
            starve_cnt_q <= '0;
            mem_hold_q   <= '0;
            dbg_hold_q   <= '0;
        end else begin
            rd_owner_q   <= rd_owner_d;
            starve_cnt_q <= starve_cnt_d;
            mem_hold_q   <= mem_hold_d;
            dbg_hold_q   <= dbg_hold_d;
        end
    end

    // Grant selection; grants are suppressed while reset is held.
    always_comb begin
        starve_hit = (starve_cnt_q == CNT_W'(STARVE_MAX));
        dbg_gnt    = ~reset & dbg_req & (~mem_req | starve_hit);
        mem_gnt    = ~reset & mem_req & ~dbg_gnt;
    end

    // RAM port mux; debug accesses are always reads.
    always_comb begin
        ram_addr  = '0;
        ram_wen   = 4'b0000;
        ram_wdata = '0;
        if (dbg_gnt) begin
            ram_addr = dbg_addr;
        end else if (mem_gnt) begin
            ram_addr  = mem_addr;
            ram_wen   = mem_wen;
            ram_wdata = mem_wdata;
        end
    end

    // Read-owner tracking and starvation counter next state.
    always_comb begin
        rd_owner_d   = RD_NONE;
        starve_cnt_d = starve_cnt_q;
        if (dbg_gnt) begin
            rd_owner_d = RD_DBG;
        end else if (mem_gnt && (mem_wen == 4'b0000)) begin
            rd_owner_d = RD_MEM;
        end

        if (!dbg_req || dbg_gnt) begin
            starve_cnt_d = '0;
        end else if (mem_gnt && (starve_cnt_q < CNT_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Read return steering with hold registers that keep the last returned word.
    always_comb begin
        mem_rvalid = ~reset & (rd_owner_q == RD_MEM);
        dbg_rvalid = ~reset & (rd_owner_q == RD_DBG);
        mem_rdata  = mem_rvalid ? ram_rdata : mem_hold_q;
        dbg_rdata  = dbg_rvalid ? ram_rdata : dbg_hold_q;
        mem_hold_d = mem_rvalid ? ram_rdata : mem_hold_q;
        dbg_hold_d = dbg_rvalid ? ram_rdata : dbg_hold_q;
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: a behavioural RAM plus a reference memory and
// per-port scoreboard queues of expected read data.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [31:0] ram_addr;
    logic [3:0]  ram_wen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        ram_loaded = 1'b0;
    logic [31:0] mem_q [$];
    logic [31:0] dbg_q [$];
    logic [31:0] mem_hold_exp;
    logic [31:0] dbg_hold_exp;

    dm_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .ram_addr   (ram_addr),
        .ram_wen    (ram_wen),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int idx);
        case (idx)
            4:       return 32'hDEADBEEF;
            8:       return 32'h12345678;
            12:      return 32'hA5A5A5A5;
            16:      return 32'h11111111;
            17:      return 32'h22222222;
            20:      return 32'hCAFEF00D;
            default: return 32'h5A000000 | 32'(idx);
        endcase
    endfunction

    // Synchronous-read RAM: data for the address presented appears after the next edge.
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) ram[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= ram[ram_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check grants, read return, RAM bus and optionally the starvation count.
    task automatic cyc(input logic emg, input logic edg, input string tag, input int exp_cnt = -1);
        logic [31:0] d;
        @(negedge clk);
        chk({tag, ".mem_gnt"}, 32'(mem_gnt), 32'(emg));
        chk({tag, ".dbg_gnt"}, 32'(dbg_gnt), 32'(edg));
        if (mem_q.size() > 0) begin
            d = mem_q.pop_front();
            chk({tag, ".mem_rvalid"}, 32'(mem_rvalid), 32'd1);
            chk({tag, ".mem_rdata"}, mem_rdata, d);
            mem_hold_exp = d;
        end else begin
            chk({tag, ".mem_rvalid"}, 32'(mem_rvalid), 32'd0);
            chk({tag, ".mem_hold"}, mem_rdata, mem_hold_exp);
        end
        if (dbg_q.size() > 0) begin
            d = dbg_q.pop_front();
            chk({tag, ".dbg_rvalid"}, 32'(dbg_rvalid), 32'd1);
            chk({tag, ".dbg_rdata"}, dbg_rdata, d);
            dbg_hold_exp = d;
        end else begin
            chk({tag, ".dbg_rvalid"}, 32'(dbg_rvalid), 32'd0);
            chk({tag, ".dbg_hold"}, dbg_rdata, dbg_hold_exp);
        end
        if (edg) begin
            chk({tag, ".ram_addr"}, ram_addr, dbg_addr);
            chk({tag, ".ram_wen"}, 32'(ram_wen), 32'd0);
            dbg_q.push_back(ref_mem[dbg_addr[9:2]]);
        end else if (emg) begin
            chk({tag, ".ram_addr"}, ram_addr, mem_addr);
            chk({tag, ".ram_wen"}, 32'(ram_wen), 32'(mem_wen));
            chk({tag, ".ram_wdata"}, ram_wdata, mem_wdata);
            if (mem_wen == 4'b0000) begin
                mem_q.push_back(ref_mem[mem_addr[9:2]]);
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_wen[b]) ref_mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end else begin
            chk({tag, ".ram_addr"}, ram_addr, 32'd0);
            chk({tag, ".ram_wen"}, 32'(ram_wen), 32'd0);
        end
        if (exp_cnt >= 0) chk({tag, ".starve_cnt"}, 32'(dut.starve_cnt_q), 32'(exp_cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_gnt"}, 32'(mem_gnt), 32'd0);
        chk({tag, ".dbg_gnt"}, 32'(dbg_gnt), 32'd0);
        chk({tag, ".mem_rvalid"}, 32'(mem_rvalid), 32'd0);
        chk({tag, ".dbg_rvalid"}, 32'(dbg_rvalid), 32'd0);
        chk({tag, ".mem_rdata"}, mem_rdata, 32'd0);
        chk({tag, ".dbg_rdata"}, dbg_rdata, 32'd0);
        chk({tag, ".ram_addr"}, ram_addr, 32'd0);
        chk({tag, ".ram_wen"}, 32'(ram_wen), 32'd0);
        chk({tag, ".ram_wdata"}, ram_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        mem_hold_exp = '0;
        dbg_hold_exp = '0;

        // Reset held with both requesters active: nothing may leak onto the RAM bus.
        reset     = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = 32'h10;
        mem_wen   = 4'hF;
        mem_wdata = 32'hFFFF_FFFF;
        dbg_req   = 1'b1;
        dbg_addr  = 32'h40;
        #2;
        @(negedge clk);
        chk_all_zero("in_reset");
        mem_req = 1'b0;
        dbg_req = 1'b0;
        mem_wen = 4'h0;
        mem_wdata = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset asserted in the rvalid cycle discards the read.
        mem_req  = 1'b1;
        mem_addr = 32'h10;
        cyc(1'b1, 1'b0, "rst_rd", 0);
        mem_req = 1'b0;
        reset   = 1'b1;
        #1;
        @(negedge clk);
        chk_all_zero("rst_mid_read");
        mem_q.delete();
        dbg_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b0, "post_rst", 0);

        // MEM read, then the returned word is held while MEM is idle.
        mem_req  = 1'b1;
        mem_addr = 32'h10;
        cyc(1'b1, 1'b0, "mrd");
        mem_req = 1'b0;
        for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b0, "mrd_hold");

        // MEM byte write: no rvalid, then read back the merged word.
        mem_req   = 1'b1;
        mem_addr  = 32'h22;
        mem_wen   = 4'b0100;
        mem_wdata = 32'h00AB0000;
        cyc(1'b1, 1'b0, "mwr");
        mem_req   = 1'b0;
        mem_wen   = 4'b0000;
        mem_wdata = '0;
        cyc(1'b0, 1'b0, "mwr_next");
        mem_req  = 1'b1;
        mem_addr = 32'h20;
        cyc(1'b1, 1'b0, "mwr_rb");
        mem_req = 1'b0;
        cyc(1'b0, 1'b0, "mwr_rb_ret");

        // Starvation: both held, debug forced through every fifth cycle.
        mem_req  = 1'b1;
        mem_addr = 32'h30;
        dbg_req  = 1'b1;
        dbg_addr = 32'h40;
        for (int i = 0; i < 10; i++)
            cyc(!(i == 4 || i == 9), (i == 4 || i == 9), "starve", i % 5);
        mem_req = 1'b0;
        dbg_req = 1'b0;
        cyc(1'b0, 1'b0, "starve_tail", 0);

        // Back-to-back: debug read then MEM read; each owner gets its own word.
        dbg_req  = 1'b1;
        dbg_addr = 32'h40;
        cyc(1'b0, 1'b1, "b2b_dbg");
        dbg_req  = 1'b0;
        mem_req  = 1'b1;
        mem_addr = 32'h44;
        cyc(1'b1, 1'b0, "b2b_mem");
        mem_req = 1'b0;
        cyc(1'b0, 1'b0, "b2b_ret");
        cyc(1'b0, 1'b0, "b2b_hold");

        // Idle debug read goes straight through, counter stays clear.
        dbg_req  = 1'b1;
        dbg_addr = 32'h50;
        cyc(1'b0, 1'b1, "idle_dbg", 0);
        dbg_req = 1'b0;
        cyc(1'b0, 1'b0, "idle_dbg_ret", 0);

        // Debug request withdrawn before its grant: counter clears, nothing issued.
        mem_req  = 1'b1;
        mem_addr = 32'h30;
        dbg_req  = 1'b1;
        dbg_addr = 32'h50;
        cyc(1'b1, 1'b0, "drop", 0);
        cyc(1'b1, 1'b0, "drop", 1);
        dbg_req = 1'b0;
        cyc(1'b1, 1'b0, "drop", 2);
        cyc(1'b1, 1'b0, "drop", 0);
        mem_req = 1'b0;
        cyc(1'b0, 1'b0, "drop_tail", 0);
        cyc(1'b0, 1'b0, "drop_hold", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single synchronous-read data RAM between two requesters:
  - the MEM stage (load/store, read/write);
  - a read-only debug/display port used to show memory contents.
- Sits between the MEM stage dm_* outputs and the data RAM.
- Multiplexes address, write-enable and write-data, and tracks which requester owns the read in flight.
- Steers the one-cycle-late read data back to that owner, with a hold register so the data stays stable after return.

Parameters:
- STARVE_MAX, 4: maximum consecutive MEM grants while the debug port is pending before the debug port is forced through. Range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_req  input  1  MEM stage access request; held until mem_gnt.
- mem_addr  input  32  MEM byte address.
- mem_wen  input  4  byte write enables; 4'b0000 means read.
- mem_wdata  input  32  MEM write data, already lane-aligned.
- mem_gnt  output  1  MEM access issued to the RAM this cycle.
- mem_rvalid  output  1  MEM read data valid this cycle.
- mem_rdata  output  32  MEM read data.
- dbg_req  input  1  debug read request; held until dbg_gnt.
- dbg_addr  input  32  debug byte address.
- dbg_gnt  output  1  debug read issued this cycle.
- dbg_rvalid  output  1  debug read data valid this cycle.
- dbg_rdata  output  32  debug read data.
- ram_addr  output  32  RAM address.
- ram_wen  output  4  RAM byte write enables.
- ram_wdata  output  32  RAM write data.
- ram_rdata  input  32  RAM read data; appears the cycle after the address.

Behaviour:
- Reset:
  - Clears rd_owner to NONE, starve_cnt to 0, mem_hold and dbg_hold to 0.
  - While reset is high, mem_gnt, dbg_gnt, mem_rvalid and dbg_rvalid are 0.
  - While reset is high, ram_wen is 4'b0000 and ram_addr/ram_wdata are 0.
  - Reset asserted mid-read discards the in-flight read; no rvalid pulse follows.
- Grant logic is combinational, at most one grant per cycle:
  - dbg_gnt = dbg_req & (~mem_req | starve_cnt == STARVE_MAX).
  - mem_gnt = mem_req & ~dbg_gnt.
- RAM mux:
  - dbg_gnt: ram_addr = dbg_addr, ram_wen = 0.
  - mem_gnt: ram_addr = mem_addr, ram_wen = mem_wen, ram_wdata = mem_wdata.
  - No grant: ram_wen = 0, ram_addr = 0.
- rd_owner register, states NONE / MEM / DBG, updated every cycle:
  - Next state is DBG on dbg_gnt.
  - Next state is MEM on a mem_gnt with mem_wen == 0.
  - Next state is NONE otherwise.
  - MEM writes never set an owner and never produce rvalid.
- Read return, one cycle after the grant:
  - mem_rvalid = (rd_owner == MEM); dbg_rvalid = (rd_owner == DBG).
  - While its rvalid is high, mem_rdata/dbg_rdata = ram_rdata.
  - Otherwise each output shows its hold register.
  - The hold register loads ram_rdata on the clock edge ending the rvalid cycle; it persists across MEM stalls.
- Back-to-back issue is allowed: a new grant can occur in the same cycle as the previous read's rvalid.
- starve_cnt, saturating 4 bits:
  - Increments when dbg_req & mem_gnt.
  - Clears on dbg_gnt or when dbg_req is low.
  - Never exceeds STARVE_MAX.
- Simultaneous requests with starve_cnt < STARVE_MAX: MEM wins.
- Simultaneous requests with starve_cnt == STARVE_MAX: DBG wins for exactly one cycle; the counter clears.
- A request dropped before its grant is legal and leaves no side effect.
- Address bits [1:0] are passed through unmodified. Alignment and lane steering belong to the MEM stage.

Test Plan:
- Reset mid-read:
  - Stimulus: mem_req, mem_wen=0, mem_addr=0x10, granted; RAM returns 0xDEADBEEF; reset asserted in the rvalid cycle.
  - Required: no mem_rvalid; all outputs 0.
  - Required after release: mem_rdata=0, starve_cnt=0.
- MEM read:
  - Stimulus: mem_req, mem_wen=0, mem_addr=0x10, RAM holds 0xDEADBEEF.
  - Required: mem_gnt cycle 0; mem_rvalid=1 with mem_rdata=0xDEADBEEF in cycle 1.
  - Required: mem_rdata stays 0xDEADBEEF in cycles 2..5 with mem_req low.
- MEM write:
  - Stimulus: mem_req, mem_wen=4'b0100, mem_addr=0x22, mem_wdata=0x00AB0000.
  - Required: ram_wen=4'b0100 and ram_wdata=0x00AB0000 in the grant cycle.
  - Required: no mem_rvalid the next cycle; rd_owner NONE.
- Starvation limit, STARVE_MAX=4:
  - Stimulus: mem_req and dbg_req held high continuously.
  - Required: mem_gnt cycles 0–3, dbg_gnt cycle 4, mem_gnt cycles 5–8, dbg_gnt cycle 9.
  - Required: dbg_rvalid cycles 5 and 10.
- Back-to-back mixed traffic:
  - Stimulus: dbg read 0x40 (data 0x11111111) in cycle 0; MEM read 0x44 (data 0x22222222) in cycle 1.
  - Required: dbg_rvalid with 0x11111111 in cycle 1; mem_rvalid with 0x22222222 in cycle 2.
  - Required: no cross-delivery; dbg_rdata holds 0x11111111 afterwards.
- Idle debug:
  - Stimulus: dbg_req only, mem_req low.
  - Required: dbg_gnt same cycle, ram_wen=0, dbg_rvalid next cycle, starve_cnt stays 0.
